// File: rtl/encoder_layer_scheduler_if.sv
// Signal bundle between the encoder scheduler, the network controller and the shared conv/pool engines.
// Handshake: start/abort come from the controller as levels sampled each clk; conv_start/pool_start and
// conv_done/pool_done are single-cycle pulses, and the cfg_* bus is held stable from a start pulse until its done.
interface encoder_layer_scheduler_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic        conv_start;
    logic        conv_done;
    logic        pool_start;
    logic        pool_done;
    logic [1:0]  cfg_stage;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic [15:0] cfg_in_ch;
    logic [15:0] cfg_out_ch;
    logic [15:0] cfg_oc_base;
    logic [15:0] cfg_oc_count;
    logic [2:0]  state;

    modport master (
        input  start, abort, conv_done, pool_done,
        output busy, done, error, conv_start, pool_start,
        output cfg_stage, cfg_width, cfg_height, cfg_in_ch, cfg_out_ch, cfg_oc_base, cfg_oc_count,
        output state
    );

    modport slave (
        output start, abort, conv_done, pool_done,
        input  busy, done, error, conv_start, pool_start,
        input  cfg_stage, cfg_width, cfg_height, cfg_in_ch, cfg_out_ch, cfg_oc_base, cfg_oc_count,
        input  state
    );
endinterface

// File: rtl/encoder_layer_scheduler.sv
// Sequences the shared conv and pool engines through the encoder stages: all conv tiles of a stage,
// then one 2x2 pool pass, with abort and a wait-state watchdog.
module encoder_layer_scheduler #(
    parameter int INPUT_WIDTH    = 224,
    parameter int INPUT_HEIGHT   = 224,
    parameter int INPUT_CHANNELS = 3,
    parameter int BASE_CHANNELS  = 64,
    parameter int NUM_STAGES     = 3,
    parameter int TILE_OC        = 16,
    parameter int WDT_WIDTH      = 24
) (
    input logic clk,
    input logic rst,
    encoder_layer_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONV_ISSUE = 3'd1,
        CONV_WAIT  = 3'd2,
        POOL_ISSUE = 3'd3,
        POOL_WAIT  = 3'd4,
        FINISH     = 3'd5,
        ERROR      = 3'd6
    } state_t;

    localparam logic [15:0] W16    = 16'(INPUT_WIDTH);
    localparam logic [15:0] H16    = 16'(INPUT_HEIGHT);
    localparam logic [15:0] IC16   = 16'(INPUT_CHANNELS);
    localparam logic [15:0] BASE16 = 16'(BASE_CHANNELS);
    localparam logic [15:0] TILE16 = 16'(TILE_OC);
    localparam logic [1:0]  LAST_STAGE = 2'(NUM_STAGES - 1);
    // One below all-ones: the counter reaches all-ones on the same edge that enters ERROR.
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = ~(WDT_WIDTH'(1));

    state_t               state_q, state_d;
    logic [1:0]           stage_q, stage_d;
    logic [15:0]          oc_base_q, oc_base_d;
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
    logic [15:0]          cur_out_ch;
    logic [16:0]          next_tile_end;
    logic                 wdt_expired;

    function automatic logic [15:0] out_ch_of(input logic [1:0] s);
        return BASE16 << s;
    endfunction

    function automatic logic [15:0] in_ch_of(input logic [1:0] s);
        return (s == 2'd0) ? IC16 : (BASE16 << (s - 2'd1));
    endfunction

    function automatic logic [15:0] oc_count_of(input logic [15:0] out_ch, input logic [15:0] base);
        logic [15:0] rem;
        rem = out_ch - base;
        return (rem < TILE16) ? rem : TILE16;
    endfunction

    assign cur_out_ch    = out_ch_of(stage_q);
    assign next_tile_end = {1'b0, oc_base_q} + {1'b0, TILE16};
    assign wdt_expired   = (wdt_q == WDT_LAST);
    assign bus.state     = state_q;

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        oc_base_d = oc_base_q;
        wdt_d     = wdt_q;
        case (state_q)
            IDLE: begin
                wdt_d = '0;
                if (bus.start && !bus.abort) begin
                    state_d   = CONV_ISSUE;
                    stage_d   = '0;
                    oc_base_d = '0;
                end
            end
            CONV_ISSUE: begin
                state_d = CONV_WAIT;
                wdt_d   = '0;
            end
            CONV_WAIT: begin
                wdt_d = wdt_q + WDT_WIDTH'(1);
                if (bus.conv_done) begin
                    if (next_tile_end < {1'b0, cur_out_ch}) begin
                        oc_base_d = next_tile_end[15:0];
                        state_d   = CONV_ISSUE;
                    end else begin
                        state_d = POOL_ISSUE;
                    end
                end else if (wdt_expired) begin
                    state_d = ERROR;
                end
            end
            POOL_ISSUE: begin
                state_d = POOL_WAIT;
                wdt_d   = '0;
            end
            POOL_WAIT: begin
                wdt_d = wdt_q + WDT_WIDTH'(1);
                if (bus.pool_done) begin
                    if (stage_q < LAST_STAGE) begin
                        stage_d   = stage_q + 2'd1;
                        oc_base_d = '0;
                        state_d   = CONV_ISSUE;
                    end else begin
                        state_d = FINISH;
                    end
                end else if (wdt_expired) begin
                    state_d = ERROR;
                end
            end
            FINISH: begin
                state_d   = IDLE;
                stage_d   = '0;
                oc_base_d = '0;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides every done and watchdog decision made above.
        if (bus.abort && state_q != IDLE) begin
            state_d   = IDLE;
            stage_d   = '0;
            oc_base_d = '0;
            wdt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            stage_q          <= '0;
            oc_base_q        <= '0;
            wdt_q            <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
            bus.conv_start   <= 1'b0;
            bus.pool_start   <= 1'b0;
            bus.cfg_stage    <= '0;
            bus.cfg_width    <= '0;
            bus.cfg_height   <= '0;
            bus.cfg_in_ch    <= '0;
            bus.cfg_out_ch   <= '0;
            bus.cfg_oc_base  <= '0;
            bus.cfg_oc_count <= '0;
        end else begin
            state_q        <= state_d;
            stage_q        <= stage_d;
            oc_base_q      <= oc_base_d;
            wdt_q          <= wdt_d;
            bus.busy       <= (state_d != IDLE) && (state_d != ERROR);
            bus.done       <= (state_d == FINISH);
            bus.error      <= (state_d == ERROR);
            bus.conv_start <= (state_d == CONV_ISSUE);
            bus.pool_start <= (state_d == POOL_ISSUE);
            // cfg only changes on entry to an ISSUE state, so it is frozen across each job.
            if (state_d == IDLE) begin
                bus.cfg_stage    <= '0;
                bus.cfg_width    <= '0;
                bus.cfg_height   <= '0;
                bus.cfg_in_ch    <= '0;
                bus.cfg_out_ch   <= '0;
                bus.cfg_oc_base  <= '0;
                bus.cfg_oc_count <= '0;
            end else if (state_d == CONV_ISSUE) begin
                bus.cfg_stage    <= stage_d;
                bus.cfg_width    <= W16 >> stage_d;
                bus.cfg_height   <= H16 >> stage_d;
                bus.cfg_in_ch    <= in_ch_of(stage_d);
                bus.cfg_out_ch   <= out_ch_of(stage_d);
                bus.cfg_oc_base  <= oc_base_d;
                bus.cfg_oc_count <= oc_count_of(out_ch_of(stage_d), oc_base_d);
            end else if (state_d == POOL_ISSUE) begin
                bus.cfg_oc_base  <= '0;
                bus.cfg_oc_count <= bus.cfg_out_ch;
            end
        end
    end

endmodule

// File: tb/tb_encoder_layer_scheduler.sv
// Directed bench for encoder_layer_scheduler: three parameterisations, engine models with fixed
// done latency, and a job scoreboard comparing every start pulse's cfg bus against a geometry model.
module tb_encoder_layer_scheduler;

    localparam int JW = 99;
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CONV_ISSUE = 3'd1;
    localparam logic [2:0] S_CONV_WAIT  = 3'd2;
    localparam logic [2:0] S_POOL_WAIT  = 3'd4;
    localparam logic [2:0] S_ERROR      = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    encoder_layer_scheduler_if d_if ();
    encoder_layer_scheduler_if p_if ();
    encoder_layer_scheduler_if w_if ();

    encoder_layer_scheduler u_def (.clk(clk), .rst(rst), .bus(d_if));
    encoder_layer_scheduler #(.BASE_CHANNELS(40), .TILE_OC(16), .NUM_STAGES(1))
        u_part (.clk(clk), .rst(rst), .bus(p_if));
    encoder_layer_scheduler #(.WDT_WIDTH(4)) u_wdt (.clk(clk), .rst(rst), .bus(w_if));

    logic d_start = 1'b0, d_abort_main = 1'b0, d_abort_eng = 1'b0;
    logic d_conv_done = 1'b0, d_pool_done = 1'b0;
    logic p_start = 1'b0, p_conv_done = 1'b0, p_pool_done = 1'b0;
    logic w_start = 1'b0, w_abort = 1'b0;

    assign d_if.start     = d_start;
    assign d_if.abort     = d_abort_main | d_abort_eng;
    assign d_if.conv_done = d_conv_done;
    assign d_if.pool_done = d_pool_done;
    assign p_if.start     = p_start;
    assign p_if.abort     = 1'b0;
    assign p_if.conv_done = p_conv_done;
    assign p_if.pool_done = p_pool_done;
    assign w_if.start     = w_start;
    assign w_if.abort     = w_abort;
    assign w_if.conv_done = 1'b0;
    assign w_if.pool_done = 1'b0;

    logic [JW-1:0] exp_q[$];
    logic [JW-1:0] part_q[$];
    logic [JW-1:0] gen_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [JW-1:0] job(input logic pool, input logic [1:0] st,
                                          input logic [15:0] w, input logic [15:0] h,
                                          input logic [15:0] ic, input logic [15:0] oc,
                                          input logic [15:0] b, input logic [15:0] c);
        return {pool, st, w, h, ic, oc, b, c};
    endfunction

    function automatic logic [105:0] def_outs();
        return {d_if.busy, d_if.done, d_if.error, d_if.conv_start, d_if.pool_start, d_if.cfg_stage,
                d_if.cfg_width, d_if.cfg_height, d_if.cfg_in_ch, d_if.cfg_out_ch,
                d_if.cfg_oc_base, d_if.cfg_oc_count, d_if.state};
    endfunction

    // Geometry model: every conv tile of each stage, then the stage's pool job.
    task automatic gen_run(input int iw, input int ih, input int ic, input int bc, input int ns, input int tile);
        gen_q.delete();
        for (int s = 0; s < ns; s++) begin
            int oc;
            int icn;
            oc  = bc << s;
            icn = (s == 0) ? ic : (bc << (s - 1));
            for (int b = 0; b < oc; b += tile)
                gen_q.push_back(job(1'b0, 2'(s), 16'(iw >> s), 16'(ih >> s), 16'(icn), 16'(oc),
                                    16'(b), 16'((oc - b < tile) ? oc - b : tile)));
            gen_q.push_back(job(1'b1, 2'(s), 16'(iw >> s), 16'(ih >> s), 16'(icn), 16'(oc), 16'(0), 16'(oc)));
        end
    endtask

    // Engine models for the default instance.
    int d_conv_lat = 5, d_pool_lat = 5, d_c_cnt = 0, d_p_cnt = 0;
    bit d_spur = 1'b0, d_abort_arm = 1'b0, d_abort_fired = 1'b0;

    always @(posedge clk) begin
        #1;
        d_conv_done = 1'b0;
        d_pool_done = 1'b0;
        d_abort_eng = 1'b0;
        if (!d_abort_arm) d_abort_fired = 1'b0;
        if (rst) begin
            d_c_cnt = 0;
            d_p_cnt = 0;
        end else begin
            if (d_c_cnt > 0) begin
                d_c_cnt--;
                if (d_c_cnt == 0) begin
                    d_conv_done = 1'b1;
                    if (d_abort_arm && !d_abort_fired && d_if.cfg_stage == 2'd1) begin
                        d_abort_eng   = 1'b1;
                        d_abort_fired = 1'b1;
                    end
                end
            end
            if (d_if.conv_start) d_c_cnt = d_conv_lat;
            if (d_p_cnt > 0) begin
                d_p_cnt--;
                if (d_p_cnt == 0) d_pool_done = 1'b1;
            end
            if (d_if.pool_start) d_p_cnt = d_pool_lat;
            if (d_spur && d_if.state == S_CONV_WAIT) d_pool_done = d_pool_done | 1'($urandom_range(0, 1));
        end
    end

    int p_c_cnt = 0, p_p_cnt = 0;
    always @(posedge clk) begin
        #1;
        p_conv_done = 1'b0;
        p_pool_done = 1'b0;
        if (p_c_cnt > 0) begin
            p_c_cnt--;
            if (p_c_cnt == 0) p_conv_done = 1'b1;
        end
        if (p_if.conv_start) p_c_cnt = 3;
        if (p_p_cnt > 0) begin
            p_p_cnt--;
            if (p_p_cnt == 0) p_pool_done = 1'b1;
        end
        if (p_if.pool_start) p_p_cnt = 3;
    end

    // Scoreboards / monitors sample on the falling edge.
    logic [JW-1:0] d_snap = '0;
    int d_conv_n = 0, d_pool_n = 0, d_done_n = 0, d_coincide = 0;
    int p_conv_n = 0, p_pool_n = 0, p_done_n = 0;
    int w_conv_n = 0, w_done_n = 0;

    always @(negedge clk) begin : mon_def
        logic [JW-1:0] obs;
        obs = job(d_if.pool_start, d_if.cfg_stage, d_if.cfg_width, d_if.cfg_height, d_if.cfg_in_ch,
                  d_if.cfg_out_ch, d_if.cfg_oc_base, d_if.cfg_oc_count);
        if (d_if.conv_start || d_if.pool_start) begin
            check("def_job_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("def_job_cfg", obs, exp_q.pop_front());
            d_snap = obs;
            if (d_if.conv_start) d_conv_n++;
            else d_pool_n++;
        end
        if ((d_if.state == S_CONV_WAIT && d_if.conv_done) || (d_if.state == S_POOL_WAIT && d_if.pool_done)) begin
            obs[JW-1] = (d_if.state == S_POOL_WAIT);
            check("def_cfg_hold", obs, d_snap);
        end
        if (d_if.done) d_done_n++;
        if (d_if.conv_start && d_if.conv_done) d_coincide++;
    end

    always @(negedge clk) begin : mon_part
        logic [JW-1:0] obs;
        obs = job(p_if.pool_start, p_if.cfg_stage, p_if.cfg_width, p_if.cfg_height, p_if.cfg_in_ch,
                  p_if.cfg_out_ch, p_if.cfg_oc_base, p_if.cfg_oc_count);
        if (p_if.conv_start || p_if.pool_start) begin
            check("part_job_expected", part_q.size() > 0, 1);
            if (part_q.size() > 0) check("part_job_cfg", obs, part_q.pop_front());
            if (p_if.conv_start) p_conv_n++;
            else p_pool_n++;
        end
        if (p_if.done) p_done_n++;
    end

    always @(negedge clk) begin
        if (w_if.conv_start) w_conv_n++;
        if (w_if.done) w_done_n++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int c0, p0, n0, k0, t0;
        bit got;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_outs_def", def_outs(), 0);
        check("rst_busy_part", p_if.busy, 0);
        check("rst_error_wdt", w_if.error, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs_def", def_outs(), 0);
        check("idle_state_wdt", w_if.state, S_IDLE);

        // Full default run, 5-cycle engines
        gen_run(224, 224, 3, 64, 3, 16);
        exp_q = gen_q;
        c0 = d_conv_n; p0 = d_pool_n; n0 = d_done_n;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        check("t1_state_issue", d_if.state, S_CONV_ISSUE);
        check("t1_conv_start_rise", d_if.conv_start, 1);
        check("t1_busy", d_if.busy, 1);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (d_if.done) begin got = 1'b1; break; end
        end
        check("t1_done_seen", got, 1);
        @(negedge clk);
        check("t1_done_one_cycle", d_if.done, 0);
        check("t1_idle_after", d_if.state, S_IDLE);
        repeat (3) @(negedge clk);
        check("t1_conv_jobs", d_conv_n - c0, 28);
        check("t1_pool_jobs", d_pool_n - p0, 3);
        check("t1_done_pulses", d_done_n - n0, 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // Minimum conv latency plus spurious pool_done during CONV_WAIT
        d_conv_lat = 1;
        d_spur = 1'b1;
        gen_run(224, 224, 3, 64, 3, 16);
        exp_q = gen_q;
        c0 = d_conv_n; p0 = d_pool_n; n0 = d_done_n; k0 = d_coincide;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (d_if.done) begin got = 1'b1; break; end
        end
        check("t3_done_seen", got, 1);
        repeat (3) @(negedge clk);
        check("t3_conv_jobs", d_conv_n - c0, 28);
        check("t3_pool_jobs", d_pool_n - p0, 3);
        check("t3_done_pulses", d_done_n - n0, 1);
        check("t3_no_coincide", d_coincide - k0, 0);
        check("t3_queue_empty", exp_q.size(), 0);
        d_spur = 1'b0;
        d_conv_lat = 5;

        // Abort coinciding with conv_done in stage 1, then restart
        gen_run(224, 224, 3, 64, 3, 16);
        exp_q = gen_q;
        n0 = d_done_n;
        d_abort_arm = 1'b1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (d_abort_fired) begin got = 1'b1; break; end
        end
        check("t4_abort_fired", got, 1);
        d_abort_arm = 1'b0;
        @(negedge clk);
        check("t4_idle_outs", def_outs(), 0);
        check("t4_jobs_consumed", exp_q.size(), 25);
        c0 = d_conv_n; p0 = d_pool_n;
        repeat (20) @(negedge clk);
        check("t4_no_conv_after", d_conv_n - c0, 0);
        check("t4_no_pool_after", d_pool_n - p0, 0);
        check("t4_no_done", d_done_n - n0, 0);
        exp_q.delete();
        gen_run(224, 224, 3, 64, 3, 16);
        exp_q = gen_q;
        c0 = d_conv_n; n0 = d_done_n;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (d_if.done) begin got = 1'b1; break; end
        end
        check("t4_restart_done", got, 1);
        repeat (3) @(negedge clk);
        check("t4_restart_conv_jobs", d_conv_n - c0, 28);
        check("t4_restart_queue_empty", exp_q.size(), 0);

        // Partial last tile: 40 channels in tiles of 16
        gen_run(224, 224, 3, 40, 1, 16);
        part_q = gen_q;
        p_start = 1'b1;
        @(negedge clk);
        p_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p_if.done) begin got = 1'b1; break; end
        end
        check("t2_done_seen", got, 1);
        repeat (3) @(negedge clk);
        check("t2_conv_jobs", p_conv_n, 3);
        check("t2_pool_jobs", p_pool_n, 1);
        check("t2_done_pulses", p_done_n, 1);
        check("t2_queue_empty", part_q.size(), 0);

        // Watchdog with a silent conv engine
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (w_if.state == S_CONV_WAIT) begin got = 1'b1; break; end
        end
        check("t5_conv_wait", got, 1);
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_if.error) begin got = 1'b1; break; end
        end
        check("t5_error_seen", got, 1);
        check("t5_error_latency", cyc - t0, 15);
        check("t5_error_state", w_if.state, S_ERROR);
        check("t5_error_busy", w_if.busy, 0);
        c0 = w_conv_n;
        w_start = 1'b1;
        repeat (3) @(negedge clk);
        w_start = 1'b0;
        check("t5_start_ignored_err", w_if.error, 1);
        check("t5_start_ignored_conv", w_conv_n - c0, 0);
        w_abort = 1'b1;
        @(negedge clk);
        w_abort = 1'b0;
        check("t5_abort_clears_error", w_if.error, 0);
        check("t5_abort_idle", w_if.state, S_IDLE);
        check("t5_no_done", w_done_n, 0);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_if.error) begin got = 1'b1; break; end
        end
        check("t5_error_again", got, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_clears_error", w_if.error, 0);
        check("t5_rst_idle", w_if.state, S_IDLE);

        // start held high through a run, rst in the middle of POOL_WAIT
        gen_run(224, 224, 3, 64, 3, 16);
        exp_q = gen_q;
        c0 = d_conv_n; p0 = d_pool_n;
        d_start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (d_if.state == S_POOL_WAIT) begin got = 1'b1; break; end
        end
        check("t6_pool_wait", got, 1);
        check("t6_stage0_conv_jobs", d_conv_n - c0, 4);
        check("t6_stage0_pool_jobs", d_pool_n - p0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_outs", def_outs(), 0);
        rst = 1'b0;
        d_start = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_stays_idle", def_outs(), 0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_layer_scheduler.md
Name: encoder_layer_scheduler

Overview:
Sequences one shared conv engine and one shared pool engine through the encoder stages. Each stage runs all of its output-channel conv tiles, then a single 2x2 pool pass. The block derives per-stage geometry from its parameters, drives the engine config buses, and handshakes with each engine using start and done pulses. It sits between the top-level network controller and the shared compute engines, and protects the encoder with abort and watchdog handling.

Parameters:
INPUT_WIDTH, 224, stage-0 feature-map width in pixels.
INPUT_HEIGHT, 224, stage-0 feature-map height in pixels.
INPUT_CHANNELS, 3, stage-0 input channel count.
BASE_CHANNELS, 64, stage-0 output channels; each later stage doubles this.
NUM_STAGES, 3, number of encoder stages (1..4).
TILE_OC, 16, output channels per conv job.
WDT_WIDTH, 24, watchdog counter width; timeout fires at 2^WDT_WIDTH-1 cycles.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin encoder run; sampled only in IDLE
abort  in  1  cancel run; returns to IDLE
busy  out  1  high in every state except IDLE and ERROR
done  out  1  one-cycle pulse when the run completes
error  out  1  high while in ERROR (watchdog expired)
conv_start  out  1  one-cycle conv job request
conv_done  in  1  conv job complete pulse
pool_start  out  1  one-cycle pool job request
pool_done  in  1  pool job complete pulse
cfg_stage  out  2  current stage index
cfg_width  out  16  stage width = INPUT_WIDTH>>stage
cfg_height  out  16  stage height = INPUT_HEIGHT>>stage
cfg_in_ch  out  16  INPUT_CHANNELS for stage 0, else BASE_CHANNELS<<(stage-1)
cfg_out_ch  out  16  BASE_CHANNELS<<stage
cfg_oc_base  out  16  first output channel of the current tile
cfg_oc_count  out  16  min(TILE_OC, cfg_out_ch-cfg_oc_base)

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - stage, oc_base and watchdog counters are 0.
- States: IDLE, CONV_ISSUE, CONV_WAIT, POOL_ISSUE, POOL_WAIT, FINISH, ERROR.
- Outputs:
  - conv_start and pool_start are registered.
  - conv_start is high only in CONV_ISSUE; pool_start is high only in POOL_ISSUE.
  - Each ISSUE state lasts exactly one cycle.
- IDLE: start=1 -> CONV_ISSUE with stage=0 and oc_base=0. conv_start rises on the cycle after start is sampled.
- CONV_ISSUE -> CONV_WAIT.
- CONV_WAIT, when conv_done=1:
  - if oc_base+TILE_OC < cfg_out_ch: oc_base += TILE_OC, go to CONV_ISSUE.
  - otherwise: go to POOL_ISSUE.
- POOL_ISSUE -> POOL_WAIT.
- POOL_WAIT, when pool_done=1:
  - if stage < NUM_STAGES-1: stage += 1, oc_base=0, go to CONV_ISSUE.
  - otherwise: go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- Done inputs:
  - conv_done and pool_done are sampled only in their own WAIT state.
  - Pulses arriving in any other state are ignored and are not queued.
- cfg_* stability: all cfg_* outputs are registered and hold stable from the ISSUE cycle until the matching done is accepted.
- Pool config: during the pool job, cfg_oc_base=0 and cfg_oc_count=cfg_out_ch.
- Width rules:
  - All cfg_* arithmetic is 16-bit unsigned.
  - cfg_oc_count correctly handles a last partial tile when cfg_out_ch is not a multiple of TILE_OC.
- Watchdog:
  - Counts cycles spent in CONV_WAIT or POOL_WAIT, and clears on every ISSUE.
  - Reaching all-ones: next state is ERROR, error=1, busy=0, no done.
- ERROR is held until abort=1 or rst.
  - abort -> IDLE next cycle and clears error.
  - start is ignored while in ERROR.
- abort in any non-IDLE state: IDLE next cycle.
  - No start or done pulse is emitted on that cycle.
  - Counters are zeroed.
  - abort takes priority over a simultaneous conv_done, pool_done or watchdog expiry.
- start while busy is ignored. start and abort together in IDLE: stay in IDLE.
- rst mid-run behaves as abort, and additionally clears error on the next edge.

Test Plan:
1. Default parameters, engines return done 5 cycles after each start:
   - 4+8+16=28 conv_start pulses and 3 pool_start pulses.
   - cfg_width sequence 224, 112, 56; cfg_in_ch sequence 3, 64, 128.
   - A single done pulse at the end.
2. BASE_CHANNELS=40, TILE_OC=16, NUM_STAGES=1: three conv jobs with (oc_base, oc_count) = (0,16), (16,16), (32,8), then one pool with cfg_oc_count=40.
3. conv_done asserted 1 cycle after conv_start (the minimum) for every job:
   - No pulse is lost.
   - conv_start never coincides with conv_done.
   - Spurious pool_done pulses during CONV_WAIT have no effect.
4. abort asserted in the same cycle as conv_done during stage 1:
   - IDLE next cycle, busy=0, no further starts, no done.
   - A new start then restarts from stage 0, oc_base=0.
5. WDT_WIDTH=4 and conv_done never asserted:
   - error=1 exactly 15 cycles after entering CONV_WAIT.
   - start is ignored; abort clears error and returns to IDLE.
6. start held high during a run plus rst pulsed mid-POOL_WAIT: one cycle after rst all outputs are 0 and the state is IDLE. Runs are not re-triggered while busy.
